// File: rtl/i2c_target_regs.sv
// I2C target with a 2^REG_AW-byte register file, oversampling SCL/SDA on clk.
// Addressed writes set a pointer and fill the file; reads stream it back open-drain.
`timescale 1ns/1ps
module i2c_target_regs #(
   parameter logic [6:0] ADDR   = 7'b1101001,
   parameter int         REG_AW = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scl,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic              wr_stb,
   output logic [REG_AW-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy
);

   localparam int DEPTH = 1 << REG_AW;

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
   } state_t;

   state_t            state, state_n;
   logic [2:0]        scl_sync, sda_sync;
   logic [3:0]        bit_cnt, bit_cnt_n;
   logic [7:0]        shreg, shreg_n;
   logic [REG_AW-1:0] ptr, ptr_n, ptr_inc;
   logic              sda_oe_n, busy_n, file_we;
   logic [7:0]        regs [DEPTH];
   logic [7:0]        shift_in, rd_byte;
   logic              scl_now, scl_prev, sda_now, sda_prev;
   logic              scl_rise, scl_fall, start_det, stop_det;

   // Bits [1:0] are the synchronizer, bit [2] the history used for edge detection.
   assign scl_now   = scl_sync[1];
   assign scl_prev  = scl_sync[2];
   assign sda_now   = sda_sync[1];
   assign sda_prev  = sda_sync[2];
   assign scl_rise  = scl_now & ~scl_prev;
   assign scl_fall  = ~scl_now & scl_prev;
   assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
   assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

   assign shift_in = {shreg[6:0], sda_now};
   assign rd_byte  = regs[ptr];
   assign ptr_inc  = ptr + 1'b1;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      ptr_n     = ptr;
      sda_oe_n  = sda_oe;
      busy_n    = busy;
      file_we   = 1'b0;
      if (start_det) begin
         state_n   = S_ADDR;
         bit_cnt_n = '0;
         sda_oe_n  = 1'b0;
      end else if (stop_det) begin
         state_n  = S_IDLE;
         sda_oe_n = 1'b0;
         busy_n   = 1'b0;
      end else begin
         case (state)
            S_IDLE: busy_n = 1'b0;
            S_ADDR, S_REG, S_WDATA: begin
               if (scl_rise && bit_cnt != 4'd8) begin
                  shreg_n   = shift_in;
                  bit_cnt_n = bit_cnt + 4'd1;
                  if (state == S_WDATA && bit_cnt == 4'd7) begin
                     file_we = 1'b1;
                     ptr_n   = ptr_inc;
                  end
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  bit_cnt_n = '0;
                  case (state)
                     S_ADDR: begin
                        if (shreg[7:1] == ADDR) begin
                           sda_oe_n = 1'b1;
                           busy_n   = 1'b1;
                           state_n  = S_ADDR_ACK;
                        end else begin
                           busy_n  = 1'b0;
                           state_n = S_IDLE;
                        end
                     end
                     S_REG: begin
                        ptr_n    = shreg[REG_AW-1:0];
                        sda_oe_n = 1'b1;
                        state_n  = S_REG_ACK;
                     end
                     default: begin
                        sda_oe_n = 1'b1;
                        state_n  = S_WDATA_ACK;
                     end
                  endcase
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  // The fall that ends the ACK also launches the first read bit.
                  if (shreg[0]) begin
                     shreg_n   = {rd_byte[6:0], 1'b0};
                     sda_oe_n  = ~rd_byte[7];
                     bit_cnt_n = 4'd1;
                     state_n   = S_RDATA;
                  end else begin
                     sda_oe_n = 1'b0;
                     state_n  = S_REG;
                  end
               end
            end
            S_REG_ACK, S_WDATA_ACK: begin
               if (scl_fall) begin
                  sda_oe_n = 1'b0;
                  state_n  = S_WDATA;
               end
            end
            S_RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oe_n = 1'b0;
                     state_n  = S_RDATA_ACK;
                  end else begin
                     sda_oe_n  = ~shreg[7];
                     shreg_n   = {shreg[6:0], 1'b0};
                     bit_cnt_n = bit_cnt + 4'd1;
                  end
               end
            end
            S_RDATA_ACK: begin
               if (scl_rise) begin
                  if (!sda_now) begin
                     ptr_n     = ptr_inc;
                     shreg_n   = regs[ptr_inc];
                     bit_cnt_n = '0;
                     state_n   = S_RDATA;
                  end else begin
                     state_n = S_WAIT;
                  end
               end
            end
            S_WAIT: ;
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         state    <= S_IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         ptr      <= '0;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         wr_stb   <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         scl_sync <= {scl_sync[1:0], scl};
         sda_sync <= {sda_sync[1:0], sda_in};
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         ptr      <= ptr_n;
         sda_oe   <= sda_oe_n;
         busy     <= busy_n;
         wr_stb   <= file_we;
         if (file_we) begin
            wr_addr <= ptr;
            wr_data <= shift_in;
         end
      end
   end

   // NOTE: the file is reset deliberately; a reset must leave every register reading 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (file_we) begin
         regs[ptr] <= shift_in;
      end
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: an I2C initiator, a byte-array model
// of the register file, a table of single-write vectors and randomized bursts.
`timescale 1ns/1ps
module tb_i2c_target_regs;

   localparam int Q = 40;   // quarter SCL period: SCL runs at 1/16 of clk

   typedef struct packed {
      logic [5:0] a;
      logic [7:0] d;
   } wr_t;

   typedef struct {
      logic [7:0] addr_b;
      logic [7:0] reg_b;
      logic [7:0] data_b;
      logic       acked;
      logic [7:0] rd;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       sda_drv = 1'b1;
   logic       sda_in;
   logic       sda_oe, wr_stb, busy;
   logic [5:0] wr_addr;
   logic [7:0] wr_data;

   int         n_vec = 0;
   int         n_err = 0;
   int         ack_total = 0;
   logic       sda_oe_q = 1'b0;
   logic       wr_stb_q = 1'b0;
   wr_t        wr_log[$];
   logic [7:0] model_mem [64];
   int         model_ptr;
   logic [7:0] tx_q[$];
   vec_t       vecs [6];

   assign sda_in = sda_drv & ~sda_oe;

   i2c_target_regs #(.ADDR(7'b1101001), .REG_AW(6)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .scl     (scl),
      .sda_in  (sda_in),
      .sda_oe  (sda_oe),
      .wr_stb  (wr_stb),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor on the falling clk edge, away from the DUT's active edge.
   always @(negedge clk) begin
      if (wr_stb) begin
         wr_log.push_back({wr_addr, wr_data});
         check("wr_stb_single_cycle", wr_stb_q, 0);
      end
      if (sda_oe && !sda_oe_q) ack_total <= ack_total + 1;
      sda_oe_q <= sda_oe;
      wr_stb_q <= wr_stb;
   end

   task automatic bus_start();
      sda_drv = 1'b1; #Q;
      scl = 1'b1;     #Q;
      sda_drv = 1'b0; #Q;
      scl = 1'b0;     #Q;
   endtask

   task automatic bus_stop();
      sda_drv = 1'b0; #Q;
      scl = 1'b1;     #Q;
      sda_drv = 1'b1; #(2*Q);
   endtask

   task automatic send_bit(input logic b);
      sda_drv = b; #Q;
      scl = 1'b1;  #(2*Q);
      scl = 1'b0;  #Q;
   endtask

   task automatic recv_bit(output logic b);
      sda_drv = 1'b1; #Q;
      scl = 1'b1;     #Q;
      b = sda_in;     #Q;
      scl = 1'b0;     #Q;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(nack);
   endtask

   // Write tx_q starting at reg_b; the model is a plain byte array with a wrapping pointer.
   task automatic do_write(input logic [7:0] reg_b);
      logic a;
      int   base, pbase, p;
      base  = wr_log.size();
      pbase = ack_total;
      bus_start();
      write_byte(8'hD2, a);
      check("wr_addr_ack", a, 0);
      write_byte(reg_b, a);
      check("wr_reg_ack", a, 0);
      foreach (tx_q[i]) begin
         write_byte(tx_q[i], a);
         check("wr_data_ack", a, 0);
      end
      bus_stop();
      check("wr_busy_after_stop", busy, 0);
      check("wr_count", wr_log.size() - base, tx_q.size());
      check("wr_ack_pulses", ack_total - pbase, tx_q.size() + 2);
      p = reg_b % 64;
      foreach (tx_q[i]) begin
         if (base + i < wr_log.size()) check("wr_word", wr_log[base + i], {p[5:0], tx_q[i]});
         model_mem[p] = tx_q[i];
         p = (p + 1) % 64;
      end
      model_ptr = p;
   endtask

   // Read n bytes (ACK all but the last), optionally setting the pointer first.
   task automatic do_read(input logic use_reg, input logic [7:0] reg_b, input int n,
                          output logic [7:0] last);
      logic       a;
      logic [7:0] d;
      int         base;
      base = wr_log.size();
      last = '0;
      bus_start();
      if (use_reg) begin
         write_byte(8'hD2, a);
         check("rd_waddr_ack", a, 0);
         write_byte(reg_b, a);
         check("rd_reg_ack", a, 0);
         model_ptr = reg_b % 64;
         bus_start();
      end
      write_byte(8'hD3, a);
      check("rd_addr_ack", a, 0);
      check("rd_busy", busy, 1);
      for (int i = 0; i < n; i++) begin
         read_byte(i == n - 1, d);
         check("rd_data", d, model_mem[model_ptr]);
         if (i != n - 1) model_ptr = (model_ptr + 1) % 64;
         last = d;
      end
      check("rd_released", sda_oe, 0);
      bus_stop();
      check("rd_busy_after_stop", busy, 0);
      check("rd_no_write", wr_log.size() - base, 0);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic       a;
      logic [7:0] rd;
      int         base, pbase, n;

      vecs[0] = '{8'hD2, 8'h25, 8'h10, 1'b1, 8'h10};
      vecs[1] = '{8'hA0, 8'h25, 8'h77, 1'b0, 8'h10};
      vecs[2] = '{8'hD2, 8'h3E, 8'hA5, 1'b1, 8'hA5};
      vecs[3] = '{8'hD4, 8'h3E, 8'h11, 1'b0, 8'hA5};
      vecs[4] = '{8'hD2, 8'h00, 8'hFF, 1'b1, 8'hFF};
      vecs[5] = '{8'hD2, 8'h7F, 8'h5A, 1'b1, 8'h5A};
      for (int i = 0; i < 64; i++) model_mem[i] = '0;
      model_ptr = 0;

      #23;
      check("reset_sda_oe", sda_oe, 0);
      check("reset_wr_stb", wr_stb, 0);
      check("reset_busy", busy, 0);
      check("reset_wr_addr", wr_addr, 0);
      check("reset_wr_data", wr_data, 0);
      #7 rst_n = 1'b1;
      #100;

      // Single-byte writes, matched and mismatched, each read back.
      for (int v = 0; v < 6; v++) begin
         base  = wr_log.size();
         pbase = ack_total;
         bus_start();
         write_byte(vecs[v].addr_b, a);
         check("vec_addr_ack", a, !vecs[v].acked);
         check("vec_busy", busy, vecs[v].acked);
         write_byte(vecs[v].reg_b, a);
         check("vec_reg_ack", a, !vecs[v].acked);
         write_byte(vecs[v].data_b, a);
         check("vec_data_ack", a, !vecs[v].acked);
         bus_stop();
         check("vec_busy_after_stop", busy, 0);
         check("vec_ack_pulses", ack_total - pbase, vecs[v].acked ? 3 : 0);
         check("vec_wr_count", wr_log.size() - base, vecs[v].acked ? 1 : 0);
         if (wr_log.size() > base)
            check("vec_wr_word", wr_log[base], {vecs[v].reg_b[5:0], vecs[v].data_b});
         if (vecs[v].acked) model_mem[vecs[v].reg_b % 64] = vecs[v].data_b;
         do_read(1'b1, vecs[v].reg_b, 1, rd);
         check("vec_readback", rd, vecs[v].rd);
      end

      // Burst write across the top of the file, then an ACKed read burst back over it.
      tx_q.delete();
      for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      do_write(8'h3E);
      do_read(1'b1, 8'h3F, 3, rd);

      // Randomized transactions against the array model.
      for (int t = 0; t < 16; t++) begin
         n = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 0) begin
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            do_write(8'($urandom_range(0, 255)));
         end else begin
            do_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), n, rd);
         end
      end

      // START after 4 data bits: no write, the next address byte still decodes.
      base = wr_log.size();
      bus_start();
      write_byte(8'hD2, a);
      write_byte(8'h10, a);
      model_ptr = 16;
      for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
      bus_start();
      write_byte(8'hD3, a);
      check("mid_addr_ack", a, 0);
      check("mid_busy", busy, 1);
      read_byte(1'b1, rd);
      check("mid_read", rd, model_mem[16]);
      bus_stop();
      check("mid_no_write", wr_log.size() - base, 0);

      // Reset while the target drives a 0 read bit.
      tx_q.delete();
      tx_q.push_back(8'h10);
      do_write(8'h25);
      bus_start();
      write_byte(8'hD2, a);
      write_byte(8'h25, a);
      bus_start();
      write_byte(8'hD3, a);
      check("rst_pre_sda_oe", sda_oe, 1);
      #3 rst_n = 1'b0;
      #1 check("rst_async_release", sda_oe, 0);
      check("rst_busy", busy, 0);
      #16 rst_n = 1'b1;
      sda_drv = 1'b1; #Q;
      scl = 1'b1;     #(2*Q);
      for (int i = 0; i < 64; i++) model_mem[i] = '0;
      model_ptr = 0;
      do_read(1'b1, 8'h25, 1, rd);
      check("rst_readback_cleared", rd, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
